// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: steps IF/ID/EXE/MEM/WB, drives PC update,
// register-file, ALU and data-memory controls, counts retired instructions
// and flags halt/illegal instructions.
module mc_control_fsm #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               PCWre,
    output logic [1:0]         PCSrc,
    output logic               IRWre,
    output logic               RegWre,
    output logic               RegDst,
    output logic               ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               ExtSel,
    output logic               MemRd,
    output logic               MemWr,
    output logic               DBDataSrc,
    output logic [2:0]         state,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    typedef enum logic [3:0] {
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_JR,
        I_ADDI,
        I_ORI,
        I_LW,
        I_SW,
        I_BEQ,
        I_J,
        I_HALT,
        I_ILL
    } instr_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;

    localparam logic [1:0] PC_INC   = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_RS    = 2'b10;
    localparam logic [1:0] PC_JMP   = 2'b11;

    state_t       state_q;
    state_t       state_d;
    instr_t       instr;
    logic         illegal_set;
    logic [2:0]   alu_op_i;
    logic         alu_src_b_i;
    logic         ext_sel_i;
    logic         pc_wre_raw;
    logic         ir_wre_raw;
    logic         reg_wre_raw;
    logic         mem_rd_raw;
    logic         mem_wr_raw;
    logic         illegal_q;
    logic [COUNT_W-1:0] retired_q;

    // Classify the instruction held in the instruction register.
    always_comb begin
        instr = I_ILL;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADD:  instr = I_ADD;
                    FN_SUB:  instr = I_SUB;
                    FN_AND:  instr = I_AND;
                    FN_OR:   instr = I_OR;
                    FN_JR:   instr = I_JR;
                    default: instr = I_ILL;
                endcase
            end
            OP_ADDI: instr = I_ADDI;
            OP_ORI:  instr = I_ORI;
            OP_LW:   instr = I_LW;
            OP_SW:   instr = I_SW;
            OP_BEQ:  instr = I_BEQ;
            OP_J:    instr = I_J;
            OP_HALT: instr = I_HALT;
            default: instr = I_ILL;
        endcase
    end

    // ALU operation, operand-B select and extension mode for this instruction;
    // set up in EXE and held through MEM/WB so the ALU result stays stable.
    always_comb begin
        alu_op_i    = ALU_ADD;
        alu_src_b_i = 1'b0;
        ext_sel_i   = 1'b0;
        case (instr)
            I_ADD:  alu_op_i = ALU_ADD;
            I_SUB:  alu_op_i = ALU_SUB;
            I_AND:  alu_op_i = ALU_AND;
            I_OR:   alu_op_i = ALU_OR;
            I_ADDI: begin
                alu_src_b_i = 1'b1;
                ext_sel_i   = 1'b1;
            end
            I_ORI: begin
                alu_op_i    = ALU_OR;
                alu_src_b_i = 1'b1;
            end
            I_LW, I_SW: begin
                alu_src_b_i = 1'b1;
                ext_sel_i   = 1'b1;
            end
            I_BEQ: begin
                alu_op_i  = ALU_SUB;
                ext_sel_i = 1'b1;
            end
            default: begin
                alu_op_i    = ALU_ADD;
                alu_src_b_i = 1'b0;
                ext_sel_i   = 1'b0;
            end
        endcase
    end

    // State register; an asynchronous reset always restarts at fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode for the current step.
    always_comb begin
        state_d     = state_q;
        illegal_set = 1'b0;
        pc_wre_raw  = 1'b0;
        PCSrc       = PC_INC;
        ir_wre_raw  = 1'b0;
        reg_wre_raw = 1'b0;
        RegDst      = 1'b0;
        ALUSrcB     = 1'b0;
        ALUOp       = ALU_ADD;
        ExtSel      = 1'b0;
        mem_rd_raw  = 1'b0;
        mem_wr_raw  = 1'b0;
        DBDataSrc   = 1'b0;
        case (state_q)
            S_IF: begin
                ir_wre_raw = 1'b1;
                state_d    = S_ID;
            end
            S_ID: begin
                case (instr)
                    I_J: begin
                        pc_wre_raw = 1'b1;
                        PCSrc      = PC_JMP;
                        state_d    = S_IF;
                    end
                    I_JR: begin
                        pc_wre_raw = 1'b1;
                        PCSrc      = PC_RS;
                        state_d    = S_IF;
                    end
                    I_HALT: state_d = S_HALT;
                    I_ILL: begin
                        illegal_set = 1'b1;
                        state_d     = S_HALT;
                    end
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                ALUOp   = alu_op_i;
                ALUSrcB = alu_src_b_i;
                ExtSel  = ext_sel_i;
                case (instr)
                    I_BEQ: begin
                        pc_wre_raw = 1'b1;
                        PCSrc      = zero ? PC_BR : PC_INC;
                        state_d    = S_IF;
                    end
                    I_LW, I_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                ALUOp   = alu_op_i;
                ALUSrcB = alu_src_b_i;
                ExtSel  = ext_sel_i;
                if (instr == I_SW) begin
                    mem_wr_raw = 1'b1;
                    pc_wre_raw = 1'b1;
                    PCSrc      = PC_INC;
                    state_d    = S_IF;
                end else begin
                    mem_rd_raw = 1'b1;
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                reg_wre_raw = 1'b1;
                pc_wre_raw  = 1'b1;
                PCSrc       = PC_INC;
                state_d     = S_IF;
                if (instr == I_LW) begin
                    mem_rd_raw = 1'b1;
                    DBDataSrc  = 1'b1;
                end else begin
                    ALUOp   = alu_op_i;
                    ALUSrcB = alu_src_b_i;
                    ExtSel  = ext_sel_i;
                    RegDst  = (instr != I_ADDI) && (instr != I_ORI);
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Enables are forced low for as long as reset is held, whatever the state.
    assign PCWre  = pc_wre_raw  & rst_n;
    assign IRWre  = ir_wre_raw  & rst_n;
    assign RegWre = reg_wre_raw & rst_n;
    assign MemRd  = mem_rd_raw  & rst_n;
    assign MemWr  = mem_wr_raw  & rst_n;

    // Sticky illegal-instruction flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (illegal_set) begin
            illegal_q <= 1'b1;
        end
    end

    // Retired count: one per instruction, on the edge that closes its PC write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (pc_wre_raw) begin
            retired_q <= retired_q + COUNT_W'(1);
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign retired = retired_q;

`ifndef SYNTHESIS
    // Memory read and write are never requested together, and HALT never moves the PC.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(MemRd && MemWr));
            assert (!(halted && PCWre));
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle expected control words
// are queued when an instruction is applied and compared on each negedge.
module tb_mc_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        IRWre;
    logic        RegWre;
    logic        RegDst;
    logic        ALUSrcB;
    logic [2:0]  ALUOp;
    logic        ExtSel;
    logic        MemRd;
    logic        MemWr;
    logic        DBDataSrc;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
    logic [31:0] retired;

    int checkCount = 0;
    int failCount  = 0;
    int retiredExp = 0;
    logic illExp   = 1'b0;
    logic [18:0] expQ[$];
    string curName = "";

    mc_control_fsm #(.COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
        .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .MemRd(MemRd), .MemWr(MemWr), .DBDataSrc(DBDataSrc), .state(state),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected control word: {state,PCWre,PCSrc,IRWre,RegWre,RegDst,ALUSrcB,ALUOp,ExtSel,MemRd,MemWr,DBDataSrc,halted,illegal}
    function automatic logic [18:0] mk(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                                       input logic irw, input logic regw, input logic regd, input logic asb,
                                       input logic [2:0] aop, input logic ext, input logic mrd, input logic mwr,
                                       input logic dbs, input logic hlt, input logic ill);
        return {st, pcw, pcs, irw, regw, regd, asb, aop, ext, mrd, mwr, dbs, hlt, ill};
    endfunction

    function automatic logic [18:0] observed();
        return {state, PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ALUOp, ExtSel,
                MemRd, MemWr, DBDataSrc, halted, illegal};
    endfunction

    // Drives one instruction (called with the DUT in IF) and queues its expected cycles.
    task automatic applyStimulus(input string name, input int haltCycles);
        logic [2:0] a;
        logic retires;
        curName = name;
        retires = 1'b1;
        zero = 1'b0;
        funct = 6'b000000;
        a = 3'b000;
        case (name)
            "add":  begin op = 6'b000000; funct = 6'b100000; a = 3'b000; end
            "sub":  begin op = 6'b000000; funct = 6'b100010; a = 3'b001; end
            "and":  begin op = 6'b000000; funct = 6'b100100; a = 3'b010; end
            "or":   begin op = 6'b000000; funct = 6'b100101; a = 3'b011; end
            "jr":   begin op = 6'b000000; funct = 6'b001000; end
            "addi": op = 6'b001000;
            "ori":  op = 6'b001101;
            "lw":   op = 6'b100011;
            "sw":   op = 6'b101011;
            "beq1": begin op = 6'b000100; zero = 1'b1; end
            "beq0": op = 6'b000100;
            "j":    op = 6'b000010;
            "halt": begin op = 6'b111111; retires = 1'b0; end
            "badop": begin op = 6'b010101; retires = 1'b0; end
            "badfn": begin op = 6'b000000; funct = 6'b111111; retires = 1'b0; end
            default: $fatal(1, "[TB] unknown instruction %s", name);
        endcase
        expQ.push_back(mk(3'd0, 0, 2'b00, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, illExp));
        case (name)
            "j":  expQ.push_back(mk(3'd1, 1, 2'b11, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, illExp));
            "jr": expQ.push_back(mk(3'd1, 1, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, illExp));
            default: expQ.push_back(mk(3'd1, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, illExp));
        endcase
        case (name)
            "add", "sub", "and", "or": begin
                expQ.push_back(mk(3'd2, 0, 2'b00, 0, 0, 0, 0, a, 0, 0, 0, 0, 0, illExp));
                expQ.push_back(mk(3'd4, 1, 2'b00, 0, 1, 1, 0, a, 0, 0, 0, 0, 0, illExp));
            end
            "addi": begin
                expQ.push_back(mk(3'd2, 0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, illExp));
                expQ.push_back(mk(3'd4, 1, 2'b00, 0, 1, 0, 1, 3'b000, 1, 0, 0, 0, 0, illExp));
            end
            "ori": begin
                expQ.push_back(mk(3'd2, 0, 2'b00, 0, 0, 0, 1, 3'b011, 0, 0, 0, 0, 0, illExp));
                expQ.push_back(mk(3'd4, 1, 2'b00, 0, 1, 0, 1, 3'b011, 0, 0, 0, 0, 0, illExp));
            end
            "lw": begin
                expQ.push_back(mk(3'd2, 0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, illExp));
                expQ.push_back(mk(3'd3, 0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 1, 0, 0, 0, illExp));
                expQ.push_back(mk(3'd4, 1, 2'b00, 0, 1, 0, 0, 3'b000, 0, 1, 0, 1, 0, illExp));
            end
            "sw": begin
                expQ.push_back(mk(3'd2, 0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, illExp));
                expQ.push_back(mk(3'd3, 1, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 1, 0, 0, illExp));
            end
            "beq1": expQ.push_back(mk(3'd2, 1, 2'b01, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0, illExp));
            "beq0": expQ.push_back(mk(3'd2, 1, 2'b00, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0, illExp));
            "halt", "badop", "badfn": begin
                if (name != "halt") illExp = 1'b1;
                for (int i = 0; i < haltCycles; i++)
                    expQ.push_back(mk(3'd5, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, illExp));
            end
            default: ;
        endcase
        if (retires) retiredExp++;
    endtask

    // Pops and compares up to n queued cycles, one per negedge.
    task automatic drain(input int n);
        int idx = 0;
        while (expQ.size() > 0 && idx < n) begin
            logic [18:0] e;
            @(negedge clk);
            e = expQ.pop_front();
            checkOutput($sformatf("%s_cyc%0d", curName, idx), 64'(observed()), 64'(e));
            idx++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runInstr(input string name);
        applyStimulus(name, 10);
        drain(64);
        checkOutput({name, "_retired"}, 64'(retired), 64'(retiredExp));
    endtask

    // Asserts reset for one edge, checking the cleared state while it is held.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        retiredExp = 0;
        illExp = 1'b0;
        expQ.delete();
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_enables", 64'({PCWre, IRWre, RegWre, MemRd, MemWr}), 64'd0);
        checkOutput("rst_flags", 64'({halted, illegal}), 64'd0);
        checkOutput("rst_retired", 64'(retired), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        op = 6'b000000;
        funct = 6'b100000;
        zero = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("por_state", 64'(state), 64'd0);
        checkOutput("por_enables", 64'({PCWre, IRWre, RegWre, MemRd, MemWr}), 64'd0);
        checkOutput("por_retired", 64'(retired), 64'd0);
        checkOutput("por_illegal", 64'(illegal), 64'd0);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("release_irwre", 64'(IRWre), 64'd1);

        runInstr("add");
        runInstr("sub");
        runInstr("and");
        runInstr("or");
        runInstr("addi");
        runInstr("ori");
        runInstr("lw");
        runInstr("sw");
        runInstr("beq1");
        runInstr("beq0");
        runInstr("j");
        runInstr("jr");

        // Reset in WB of an add: enables must drop immediately.
        applyStimulus("add", 0);
        drain(3);
        @(negedge clk);
        checkOutput("midrst_wb", 64'(observed()), 64'(expQ.pop_front()));
        #1;
        doReset();
        runInstr("add");

        // HALT opcode: absorbing, retired frozen.
        applyStimulus("halt", 10);
        drain(64);
        checkOutput("halt_retired", 64'(retired), 64'(retiredExp));
        doReset();

        applyStimulus("badop", 10);
        drain(64);
        checkOutput("badop_illegal", 64'(illegal), 64'd1);
        doReset();

        applyStimulus("badfn", 3);
        drain(64);
        checkOutput("badfn_illegal", 64'(illegal), 64'd1);
        doReset();

        runInstr("lw");

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
